ifetch_unit: RTL

- Fetch side of the core front end: consumes the current program counter from the PC register block and issues instruction-memory reads at that address.
- Drives the PC-advance strobe back to the PC block.
- Buffers returned instruction words in a small in-order prefetch queue and presents them, tagged with their PC, to decode over a valid/ready handshake.
- Discards in-flight and buffered fetches on a taken branch.

---
 rtl/ifetch_unit.sv | 113 +++++++++++
 1 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch: issues imem reads at the current PC and buffers the returned
// words, tagged with their PC, in an in-order prefetch queue toward decode.
module ifetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] pc_i,
    input  logic        branch_taken_i,
    output logic        incr_pc_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic        busy_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic          started;
    logic [CW-1:0] count;
    logic [CW-1:0] outst;
    logic [CW-1:0] discard;
    logic [PW-1:0] q_wr;
    logic [PW-1:0] q_rd;
    logic [PW-1:0] t_wr;
    logic [PW-1:0] t_rd;

    logic [31:0] q_data [DEPTH];
    logic [31:0] q_pc   [DEPTH];
    logic [31:0] tag    [DEPTH];

    logic room;
    logic accept;
    logic dropping;
    logic deliver;
    logic pop;

    // Queued plus in-flight words never exceed DEPTH, so a response always has a slot.
    assign room = ({1'b0, count} + {1'b0, outst}) < (CW + 1)'(DEPTH);

    assign imem_req_o  = started & ~branch_taken_i & room;
    assign imem_addr_o = pc_i;
    assign accept      = imem_req_o & imem_gnt_i;
    assign incr_pc_o   = accept;

    assign dropping = discard != '0;
    assign deliver  = imem_rvalid_i & ~branch_taken_i & ~dropping;

    assign instr_valid_o = count != '0;
    assign pop           = instr_valid_o & instr_ready_i & ~branch_taken_i;
    assign instr_o       = instr_valid_o ? q_data[q_rd] : '0;
    assign instr_pc_o    = instr_valid_o ? q_pc[q_rd] : '0;

    assign busy_o = (outst != '0) | dropping;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            started <= 1'b0;
            count   <= '0;
            outst   <= '0;
            discard <= '0;
            q_wr    <= '0;
            q_rd    <= '0;
            t_wr    <= '0;
            t_rd    <= '0;
        end else begin
            started <= 1'b1;
            // Tracks physical requests regardless of flushes.
            outst   <= outst + CW'(accept) - CW'(imem_rvalid_i);
            if (branch_taken_i) begin
                count   <= '0;
                q_wr    <= '0;
                q_rd    <= '0;
                t_wr    <= '0;
                t_rd    <= '0;
                discard <= outst - CW'(imem_rvalid_i);
            end else begin
                count <= count + CW'(deliver) - CW'(pop);
                if (accept) begin
                    t_wr <= t_wr + 1'b1;
                end
                if (deliver) begin
                    t_rd <= t_rd + 1'b1;
                    q_wr <= q_wr + 1'b1;
                end
                if (pop) begin
                    q_rd <= q_rd + 1'b1;
                end
                if (dropping && imem_rvalid_i) begin
                    discard <= discard - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            tag[t_wr] <= pc_i;
        end
        if (deliver) begin
            q_data[q_wr] <= imem_rdata_i;
            q_pc[q_wr]   <= tag[t_rd];
        end
    end

endmodule
